// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared types and helpers for the NCO frequency-sweep controller.
//   state_e  : sweep FSM states
//   APR_DEF  : default phase-increment width (matches NCO apr)
//   sat_add  : unsigned add clamped at a limit, with a hit flag
package nco_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int APR_DEF = 32;

    // Working width of sat_add; callers zero-extend into it, so any APR up
    // to SAT_W is supported and the extra sum bit catches the carry out.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             hit;   // sum reached or passed lim
        logic [SAT_W-1:0] val;   // min(a + b, lim)
    } sat_res_t;

    function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                         input logic [SAT_W-1:0] b,
                                         input logic [SAT_W-1:0] lim);
        logic [SAT_W:0] sum;
        sat_res_t       r;
        sum   = {1'b0, a} + {1'b0, b};
        r.hit = (sum >= {1'b0, lim});
        r.val = r.hit ? lim : sum[SAT_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// nco_dwell_timer: hold-time counter for one sweep value.
//   clk, reset : clock, synchronous active-high reset
//   load       : (re)start the hold for a value appearing next cycle
//   len        : hold length in cycles; 0 is treated as 1
//   expire     : high on the last hold cycle of the current value
module nco_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    // cnt_q counts the hold cycles remaining after the current one, so the
    // value is loaded as len-1 and expiry is simply cnt_q == 0.
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (len == '0) ? '0 : len - DWELL_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: linear frequency-sweep controller feeding an NCO.
//   clk, reset   : clock, synchronous active-high reset
//   start        : 1-cycle request to latch config and begin (IDLE only)
//   abort        : terminate any active sweep, back to IDLE
//   cont         : 0 single-shot, 1 continuous wrap (sampled at start)
//   f_start/f_stop/f_step : sweep range and increment (unsigned)
//   dwell        : cycles each value is held (0 acts as 1)
//   phi_inc_o    : registered phase increment to the NCO
//   clken_o      : registered NCO clock enable
//   busy         : high while in RUN or LAST
//   done         : 1-cycle pulse when a single-shot sweep completes
//   cfg_err      : 1-cycle pulse when a start is rejected
//   step_cnt     : index of the current value, saturating
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR     = APR_DEF,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [APR-1:0]     f_start,
    input  logic [APR-1:0]     f_stop,
    input  logic [APR-1:0]     f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [APR-1:0]     phi_inc_o,
    output logic               clken_o,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   step_cnt
);

    state_e             state_q, state_d;
    logic [APR-1:0]     phi_q, phi_d;
    logic               clken_q, clken_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [APR-1:0]     cfg_start_q, cfg_start_d;
    logic [APR-1:0]     cfg_stop_q, cfg_stop_d;
    logic [APR-1:0]     cfg_step_q, cfg_step_d;
    logic [DWELL_W-1:0] cfg_dwell_q, cfg_dwell_d;
    logic               cfg_cont_q, cfg_cont_d;

    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_len;
    logic               tmr_expire;
    logic               cfg_ok;
    logic [CNT_W-1:0]   cnt_inc;
    sat_res_t           sat;

    // The first load happens on the start cycle itself, before the config
    // registers hold the new dwell, so take it straight from the port then.
    assign tmr_len = (state_q == ST_IDLE) ? dwell : cfg_dwell_q;

    nco_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    assign cfg_ok  = (f_step != '0) && (f_stop >= f_start);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        phi_d       = phi_q;
        clken_d     = clken_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        cfg_start_d = cfg_start_q;
        cfg_stop_d  = cfg_stop_q;
        cfg_step_d  = cfg_step_q;
        cfg_dwell_d = cfg_dwell_q;
        cfg_cont_d  = cfg_cont_q;
        tmr_load    = 1'b0;
        sat         = sat_add(SAT_W'(phi_q), SAT_W'(cfg_step_q), SAT_W'(cfg_stop_q));

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        cfg_start_d = f_start;
                        cfg_stop_d  = f_stop;
                        cfg_step_d  = f_step;
                        cfg_dwell_d = dwell;
                        cfg_cont_d  = cont;
                        phi_d       = f_start;
                        clken_d     = 1'b1;
                        cnt_d       = '0;
                        tmr_load    = 1'b1;
                        // A one-point sweep goes straight to LAST so the
                        // single value is held once, not twice.
                        state_d     = (f_start == f_stop) ? ST_LAST : ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (tmr_expire) begin
                    // sat_add clamps at f_stop and absorbs any carry out,
                    // so the sweep never wraps to low values.
                    phi_d    = APR'(sat.val);
                    cnt_d    = cnt_inc;
                    tmr_load = 1'b1;
                    state_d  = sat.hit ? ST_LAST : ST_RUN;
                end
            end
            ST_LAST: begin
                if (tmr_expire) begin
                    if (cfg_cont_q) begin
                        phi_d    = cfg_start_q;
                        cnt_d    = '0;
                        tmr_load = 1'b1;
                        state_d  = (cfg_start_q == cfg_stop_q) ? ST_LAST : ST_RUN;
                    end else begin
                        clken_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            phi_d    = '0;
            clken_d  = 1'b0;
            cnt_d    = '0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phi_q       <= '0;
            clken_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            cfg_start_q <= '0;
            cfg_stop_q  <= '0;
            cfg_step_q  <= '0;
            cfg_dwell_q <= '0;
            cfg_cont_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_d;
            clken_q     <= clken_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            cfg_start_q <= cfg_start_d;
            cfg_stop_q  <= cfg_stop_d;
            cfg_step_q  <= cfg_step_d;
            cfg_dwell_q <= cfg_dwell_d;
            cfg_cont_q  <= cfg_cont_d;
        end
    end

    assign phi_inc_o = phi_q;
    assign clken_o   = clken_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_LAST);
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = err_q;
    assign step_cnt  = cnt_q;

endmodule
